// File: rtl/acc_pkg.sv
// Shared types and constants for the 4-bit accumulator and its downstream wrap framer.
package acc_pkg;

  localparam int ACC_W         = 4;
  localparam int FRAME_LEN_DEF = 16;
  localparam int WRAP_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/acc_wrap_detect.sv
// Flags a wrap whenever the accumulator value drops below the previous cycle's value.
module acc_wrap_detect
  import acc_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic [ACC_W-1:0] acc_in,
  output logic             wrap,
  output logic             wrap_pulse
);

  logic [ACC_W-1:0] prev_acc;

  // The addend never exceeds 15, so a carry always leaves a strictly smaller value.
  assign wrap = (acc_in < prev_acc);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      prev_acc   <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      prev_acc   <= acc_in;
      wrap_pulse <= wrap;
    end
  end

endmodule

// File: rtl/acc_wrap_framer.sv
// Counts accumulator wraps over a programmable frame and hands out {wrap count, final value}.
module acc_wrap_framer
  import acc_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int WRAP_W    = WRAP_W_DEF
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [ACC_W-1:0]        acc_in,
  input  logic                    start,
  output logic                    busy,
  output logic                    wrap_pulse,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WRAP_W+ACC_W-1:0] out_total,
  output logic                    out_ovf
);

  // Handshake: out_valid rises once per frame and stays high with out_total/out_ovf
  // frozen until the edge where out_valid && out_ready; it drops after that edge.

  state_t            state;
  logic [7:0]        cyc_cnt;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              ovf;
  logic              wrap;

  logic [WRAP_W-1:0] wrap_cnt_next;
  logic              ovf_next;
  logic              last_cycle;

  acc_wrap_detect u_detect (
    .clk        (clk),
    .clear      (clear),
    .acc_in     (acc_in),
    .wrap       (wrap),
    .wrap_pulse (wrap_pulse)
  );

  // Saturating count; the final RUN cycle's wrap must land in the captured result.
  always_comb begin
    wrap_cnt_next = wrap_cnt;
    ovf_next      = ovf;
    if (wrap) begin
      if (&wrap_cnt) begin
        ovf_next = 1'b1;
      end else begin
        wrap_cnt_next = wrap_cnt + 1'b1;
      end
    end
  end

  assign last_cycle = (cyc_cnt == 8'(FRAME_LEN - 1));
  assign busy       = (state == RUN) || (state == HOLD);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      wrap_cnt  <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_total <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            cyc_cnt  <= '0;
            wrap_cnt <= '0;
            ovf      <= 1'b0;
          end
        end
        RUN: begin
          cyc_cnt  <= cyc_cnt + 8'd1;
          wrap_cnt <= wrap_cnt_next;
          ovf      <= ovf_next;
          if (last_cycle) begin
            out_total <= {wrap_cnt_next, acc_in};
            out_ovf   <= ovf_next;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/acc_wrap_framer.md
# acc_wrap_framer

Downstream companion to the 4-bit unsigned up accumulator. Every cycle it watches the accumulator's registered output and detects wrap-around (carry out of bit 3). Over a frame of programmable length it counts wraps. At frame end it presents one extended result, {wrap count, final accumulator value}, on a valid/ready output. It shares the accumulator's clock and asynchronous clear.

## Interface
Parameters:
- FRAME_LEN, 16, frame length in cycles; legal range 1..255.
- WRAP_W, 8, width of the wrap counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- clear  in  1  asynchronous, active-high reset. Same net as the accumulator's clear.
- acc_in  in  4  registered accumulator output (unsigned).
- start  in  1  request a frame; sampled only in IDLE.
- busy  out  1  high in RUN and HOLD.
- wrap_pulse  out  1  one-cycle registered pulse per detected wrap.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_total  out  WRAP_W+4  {wrap_cnt, acc_in at last frame cycle}.
- out_ovf  out  1  wrap counter saturated during the frame.

## Operation
- Wrap detection runs continuously, in all states.
  - prev_acc <= acc_in every cycle.
  - wrap = (acc_in < prev_acc).
  - Exact because the addend is at most 15: any carry leaves a value strictly smaller than the previous one. Addend 0 leaves the value unchanged, so no wrap.
- FSM states are IDLE, RUN and HOLD.
  - IDLE: on start=1, go to RUN; wrap_cnt <= 0, cyc_cnt <= 0, ovf <= 0.
  - RUN: cyc_cnt increments each cycle. A wrap increments wrap_cnt. If wrap_cnt is already all-ones, the count holds and ovf <= 1.
  - RUN exit: when cyc_cnt == FRAME_LEN-1, capture out_total <= {wrap_cnt_next, acc_in} and out_ovf <= ovf_next, then go to HOLD.
  - HOLD: out_valid=1. On out_valid && out_ready, go to IDLE.
- start is ignored in RUN and HOLD. A pending start must be re-asserted in IDLE.
- A wrap on the final RUN cycle is included in the result (wrap_cnt_next / ovf_next).
- out_total and out_ovf are stable throughout HOLD, whatever out_ready does.
- Arithmetic: all unsigned. No modular wrap of wrap_cnt; it saturates.

## Timing
- Reset (clear=1), asynchronous, takes effect immediately:
  - state=IDLE; prev_acc=0; wrap_cnt=0; cyc_cnt=0.
  - wrap_pulse=0, out_valid=0, out_total=0, out_ovf=0, busy=0.
- Because prev_acc resets to 0 together with the accumulator, the first value after clear never flags a false wrap.
- clear asserted mid-RUN or mid-HOLD aborts the frame and discards the result.
- wrap_pulse is high in the cycle after acc_in drops.
- Frame latency: start sampled at edge N puts the FSM in RUN from N.
  - RUN samples acc_in at edges N+1 .. N+FRAME_LEN.
  - out_valid rises after edge N+FRAME_LEN.
- Handshake: the transfer occurs on the edge where out_valid=1 and out_ready=1. out_valid drops after that edge.
- Minimum IDLE gap between frames is one cycle.
- busy is combinational from state. All other outputs are registered.

## Structure
- Shared package acc_pkg holds:
  - typedef enum for the framer FSM state {IDLE, RUN, HOLD};
  - localparam ACC_W = 4;
  - defaults for FRAME_LEN and WRAP_W.
- One sub-module, acc_wrap_detect: prev_acc register, compare, registered wrap_pulse, async clear. The top instantiates it and consumes its combinational wrap signal for counting.
- The top holds the FSM, cycle counter, saturating wrap counter and output registers.

## Test plan
- **Reset values:** assert clear mid-simulation, then release. All outputs are 0 and busy=0; acc_in=0 produces no wrap_pulse.
- **Wrap pulse:** acc_in sequence 0,5,10,15,4 -> exactly one wrap_pulse, in the cycle after 4 appears.
- **Frame without wrap:** FRAME_LEN=4, start, acc_in 3,6,9,12 -> out_total=12, out_ovf=0, out_valid rises 4 cycles after the start edge.
- **Frame with saturation:** FRAME_LEN=8, WRAP_W=2, constant addend 15 from acc=0 (acc_in 15,14,13,...). Wraps occur on 7 of 8 cycles -> wrap_cnt saturates at 3, out_ovf=1, out_total = {2'b11, 4'd8}.
- **Backpressure:** hold out_ready low for 5 cycles in HOLD and pulse start during HOLD -> out_valid stays high and out_total is unchanged. The start is ignored: FSM goes to IDLE on the ready edge and no new frame begins.
- **Clear mid-frame:** assert clear at RUN cycle 2 -> FSM returns to IDLE immediately, out_valid is never asserted, and the next frame counts from wrap_cnt=0.
